spi_slave_if: RTL

- Serial front end for the single-port RAM command channel; converts 4-wire SPI (SS_n/MOSI/MISO, single-clock-domain sampling on clk) into the 10-bit parallel command word plus rx_valid strobe the RAM consumes.
- Serialises the RAM's 8-bit read-data reply (tx_data/tx_valid) back to the master on MISO.
- Sits between the external SPI master and the RAM in the SPI_RAM wrapper.

---
 rtl/spi_pkg.sv | 21 ++
 rtl/spi_tx_serializer.sv | 43 ++++
 rtl/spi_slave_if.sv | 95 +++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared encodings and defaults for the SPI slave front end of the SPI_RAM wrapper.
package spi_pkg;
  localparam int CMD_W_DEF  = 10;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'b000,
    CHK_CMD   = 3'b001,
    WRITE     = 3'b010,
    READ_ADD  = 3'b011,
    READ_DATA = 3'b100
  } state_t;

  // Interpreted by the RAM; the slave only looks at bit 9 to pick a branch.
  typedef enum logic [1:0] {
    WR_ADDR = 2'b00,
    WR_DATA = 2'b01,
    RD_ADDR = 2'b10,
    RD_DATA = 2'b11
  } cmd_t;
endpackage

// File: rtl/spi_tx_serializer.sv
// Parallel-in/serial-out reply register: load latches a word, each enabled edge drives the next MSB.
module spi_tx_serializer #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              load,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  output logic              miso,
  output logic              done
);
  localparam int CW = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] sreg;
  logic [CW-1:0]     cnt;

  // High on the edge that drives the final bit.
  assign done = en && !clr && !load && (cnt == CW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg <= '0;
      cnt  <= '0;
      miso <= 1'b0;
    end else if (clr) begin
      sreg <= '0;
      cnt  <= '0;
      miso <= 1'b0;
    end else if (load) begin
      sreg <= din;
      cnt  <= CW'(DATA_W);
      miso <= 1'b0;
    end else if (en && cnt != '0) begin
      miso <= sreg[DATA_W-1];
      sreg <= {sreg[DATA_W-2:0], 1'b0};
      cnt  <= cnt - CW'(1);
    end else begin
      miso <= 1'b0;
    end
  end
endmodule

// File: rtl/spi_slave_if.sv
// SPI slave: assembles 10-bit RAM command words from MOSI and returns 8-bit read data on MISO.
module spi_slave_if
  import spi_pkg::*;
#(
  parameter int CMD_W  = CMD_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SS_n,
  input  logic              MOSI,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              MISO,
  output logic [CMD_W-1:0]  rx_data,
  output logic              rx_valid
);
  localparam int CNT_W = $clog2(CMD_W);

  state_t           state, state_nxt;
  logic [CMD_W-2:0] shreg;
  logic [CNT_W-1:0] bit_cnt;
  logic             rcv_done, tx_started, rd_addr_seen;
  logic             abort, word_last, tx_load, tx_done, rcv_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rcv_state = (state == WRITE) || (state == READ_ADD) || (state == READ_DATA);
    abort     = (state != IDLE) && SS_n;
    word_last = rcv_state && !SS_n && !rcv_done && (bit_cnt == CNT_W'(CMD_W - 2));
    tx_load   = (state == READ_DATA) && !SS_n && rcv_done && !tx_started && tx_valid;
    case (state)
      IDLE:    if (!SS_n) state_nxt = CHK_CMD;
      CHK_CMD: begin
        if (SS_n)              state_nxt = IDLE;
        else if (!MOSI)        state_nxt = WRITE;
        else if (rd_addr_seen) state_nxt = READ_DATA;
        else                   state_nxt = READ_ADD;
      end
      default: if (SS_n) state_nxt = IDLE;
    endcase
  end

  // Receive shifter holds bits 9..1; bit 0 is merged straight into rx_data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg        <= '0;
      bit_cnt      <= '0;
      rcv_done     <= 1'b0;
      tx_started   <= 1'b0;
      rd_addr_seen <= 1'b0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
    end else begin
      rx_valid <= word_last;
      if (abort || state == IDLE) begin
        bit_cnt    <= '0;
        rcv_done   <= 1'b0;
        tx_started <= 1'b0;
      end else if (state == CHK_CMD) begin
        shreg      <= {{(CMD_W-2){1'b0}}, MOSI};
        bit_cnt    <= '0;
        rcv_done   <= 1'b0;
        tx_started <= 1'b0;
      end else begin
        if (word_last) begin
          rcv_done <= 1'b1;
          rx_data  <= {shreg, MOSI};
          if (state == READ_ADD) rd_addr_seen <= 1'b1;
        end else if (!rcv_done) begin
          shreg   <= {shreg[CMD_W-3:0], MOSI};
          bit_cnt <= bit_cnt + CNT_W'(1);
        end
        if (tx_load) tx_started   <= 1'b1;
        if (tx_done) rd_addr_seen <= 1'b0;
      end
    end
  end

  spi_tx_serializer #(.DATA_W(DATA_W)) u_tx (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (abort),
    .load  (tx_load),
    .en    (state == READ_DATA),
    .din   (tx_data),
    .miso  (MISO),
    .done  (tx_done)
  );
endmodule
